axis_rx_framer: RTL

- Read-side consumer of the RX byte-count FIFO (256x64) and the RX data FIFO in the AXIS bridge.
- Pops one byte-count/status word per frame, then pops ceil(bcnt/8) data words.
- Drives them out as one AXI-Stream frame with tkeep on the last beat, tlast, and an error flag in tuser.
- Runs entirely in the FIFOs' read clock domain.

---
 rtl/axis_rx_pkg.sv | 40 ++++
 rtl/axis_skid2.sv | 62 ++++++
 rtl/axis_rx_framer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/axis_rx_pkg.sv
// Shared field offsets, state encoding and beat layout for the RX framer.
// Imported by axis_rx_framer and its skid buffer.
package axis_rx_pkg;

    localparam int BYTES_PER_WORD = 8;
    localparam int WORD_SHIFT     = 3;
    localparam int BCNT_LSB       = 0;
    localparam int BCNT_W         = 14;
    localparam int CRC_ERR_BIT    = 14;
    localparam int LEN_ERR_BIT    = 15;
    localparam int WORDS_W        = BCNT_W + 1 - WORD_SHIFT;

    localparam logic [BCNT_W:0] WORD_ROUND = 15'd7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CNT_WAIT = 2'd1,
        STREAM   = 2'd2,
        DRAIN    = 2'd3
    } rx_state_e;

    typedef struct packed {
        logic        last;
        logic        user;
        logic [7:0]  keep;
        logic [63:0] data;
    } beat_t;

    // Byte enables for the final word of a frame; zero remainder means a full word.
    function automatic logic [7:0] keep_from_rem(input logic [2:0] rem);
        logic [7:0] keep;
        if (rem == 3'd0) begin
            keep = 8'hFF;
        end else begin
            keep = (8'd1 << rem) - 8'd1;
        end
        return keep;
    endfunction

endpackage

// File: rtl/axis_skid2.sv
// Two-entry valid/ready buffer; head entry drives the stream outputs directly
// so the payload stays put while the consumer stalls.
module axis_skid2
    import axis_rx_pkg::*;
#(
    parameter int WIDTH = $bits(beat_t)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       occupancy_o
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       count_q;
    logic             pop;

    assign pop         = (count_q != 2'd0) && ready_i;
    assign valid_o     = (count_q != 2'd0);
    assign data_o      = head_q;
    assign occupancy_o = count_q;

    // The producer never pushes into a full buffer, so no overflow case exists.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case ({push_i, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_q <= push_data_i;
                    end else begin
                        tail_q <= push_data_i;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_q <= push_data_i;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= push_data_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/axis_rx_framer.sv
// Pops one byte-count word per frame, then its data words, and emits them as
// an AXI-Stream frame; oversized and empty frames are discarded and counted.
module axis_rx_framer
    import axis_rx_pkg::*;
#(
    parameter int          DATA_W    = 64,
    parameter int          CNT_W     = 64,
    parameter int unsigned MAX_BYTES = 9600
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cnt_rdempty,
    output logic              cnt_rden,
    input  logic [CNT_W-1:0]  cnt_dataout,
    input  logic              dat_rdempty,
    output logic              dat_rden,
    input  logic [DATA_W-1:0] dat_dataout,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [7:0]        m_axis_tkeep,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    input  logic              m_axis_tready,
    output logic [15:0]       drop_cnt
);

    rx_state_e          state_q;
    logic [WORDS_W-1:0] wordsLeft_q;
    logic [7:0]         lastKeep_q;
    logic               frameErr_q;
    logic               inflight_q;
    logic               inflightLast_q;
    logic [15:0]        dropCnt_q;

    logic [BCNT_W-1:0]  bcnt;
    logic [BCNT_W:0]    bcntRound;
    logic [WORDS_W-1:0] bcntWords;
    logic               cntErr;
    logic               unusedCntBits;

    beat_t              pushBeat;
    beat_t              headBeat;
    logic               skidValid;
    logic [1:0]         skidOcc;
    logic               accept;
    logic               lastAccept;
    logic               roomInSkid;
    logic               datRden;
    logic               cntRden;
    logic               dropInc;

    assign bcnt          = cnt_dataout[BCNT_LSB +: BCNT_W];
    assign cntErr        = cnt_dataout[CRC_ERR_BIT] | cnt_dataout[LEN_ERR_BIT];
    assign bcntRound     = {1'b0, bcnt} + WORD_ROUND;
    assign bcntWords     = bcntRound[BCNT_W:WORD_SHIFT];
    assign unusedCntBits = ^cnt_dataout[CNT_W-1:LEN_ERR_BIT+1];

    assign accept     = skidValid & m_axis_tready;
    assign lastAccept = accept & headBeat.last;

    // A beat leaving this cycle frees a slot, which keeps the stream at one beat per clock.
    assign roomInSkid = ({1'b0, skidOcc} + {2'b00, inflight_q}) < (3'd2 + {2'b00, accept});

    assign datRden = (wordsLeft_q != '0) && !dat_rdempty &&
                     ((state_q == STREAM && roomInSkid) || state_q == DRAIN);
    assign cntRden = !cnt_rdempty &&
                     (state_q == IDLE || (state_q == STREAM && lastAccept));
    assign dropInc = (state_q == CNT_WAIT && bcnt == '0) ||
                     (state_q == DRAIN && wordsLeft_q == '0);

    always_comb begin
        pushBeat.data = dat_dataout;
        pushBeat.last = inflightLast_q;
        pushBeat.user = inflightLast_q & frameErr_q;
        pushBeat.keep = inflightLast_q ? lastKeep_q : 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            wordsLeft_q    <= '0;
            lastKeep_q     <= 8'h00;
            frameErr_q     <= 1'b0;
            inflight_q     <= 1'b0;
            inflightLast_q <= 1'b0;
            dropCnt_q      <= 16'h0000;
        end else begin
            inflight_q     <= datRden && (state_q == STREAM);
            inflightLast_q <= (wordsLeft_q == WORDS_W'(1));
            if (datRden) begin
                wordsLeft_q <= wordsLeft_q - WORDS_W'(1);
            end
            if (dropInc && dropCnt_q != 16'hFFFF) begin
                dropCnt_q <= dropCnt_q + 16'd1;
            end
            case (state_q)
                IDLE: begin
                    if (cntRden) begin
                        state_q <= CNT_WAIT;
                    end
                end
                CNT_WAIT: begin
                    lastKeep_q  <= keep_from_rem(bcnt[WORD_SHIFT-1:0]);
                    frameErr_q  <= cntErr;
                    wordsLeft_q <= bcntWords;
                    if (bcnt == '0) begin
                        state_q <= IDLE;
                    end else if (32'(bcnt) > MAX_BYTES) begin
                        state_q <= DRAIN;
                    end else begin
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (lastAccept) begin
                        state_q <= cntRden ? CNT_WAIT : IDLE;
                    end
                end
                DRAIN: begin
                    if (wordsLeft_q == '0) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    axis_skid2 #(
        .WIDTH($bits(beat_t))
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .push_i      (inflight_q),
        .push_data_i (pushBeat),
        .ready_i     (m_axis_tready),
        .valid_o     (skidValid),
        .data_o      (headBeat),
        .occupancy_o (skidOcc)
    );

    assign cnt_rden      = cntRden;
    assign dat_rden      = datRden;
    assign m_axis_tvalid = skidValid;
    assign m_axis_tdata  = headBeat.data;
    assign m_axis_tkeep  = headBeat.keep;
    assign m_axis_tlast  = headBeat.last;
    assign m_axis_tuser  = headBeat.user;
    assign drop_cnt      = dropCnt_q;

endmodule
